auction_seq: RTL and testbench

AUCTION_SEQ -- requirements
Module: auction_seq

---
 rtl/auction_seq_if.sv | 25 ++
 rtl/auction_seq.sv | 90 +++++++++
 tb/tb_auction_seq.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/auction_seq_if.sv
// Bid/result handshake bundle for auction_seq.
// The slave side is the auctioneer; the master side supplies bids and consumes results.
interface auction_seq_if #(
   parameter int unsigned N = 2,
   parameter int unsigned W = 2
);
   logic [W-1:0] bid_in;
   logic         bid_valid;
   logic         bid_ready;
   logic [N-1:0] winner;
   logic [W-1:0] winning_bid;
   logic [W-1:0] price;
   logic         result_valid;
   logic         result_ready;

   modport master (
      output bid_in, bid_valid, result_ready,
      input  bid_ready, winner, winning_bid, price, result_valid
   );

   modport slave (
      input  bid_in, bid_valid, result_ready,
      output bid_ready, winner, winning_bid, price, result_valid
   );
endinterface

// File: rtl/auction_seq.sv
// Sequential sealed-bid auction: collects 2**N bids, tracks the highest and second-highest,
// then presents winner and price (first- or second-price) until the consumer takes them.
module auction_seq #(
   parameter int unsigned N            = 2,
   parameter int unsigned W            = 2,
   parameter int unsigned SECOND_PRICE = 0
) (
   input logic           clk,
   input logic           rst,
   auction_seq_if.slave  bus
);

   typedef enum logic [0:0] {StCollect, StDone} state_e;

   localparam logic [N-1:0] CntLast = {N{1'b1}};

   state_e       state_q, state_d;
   logic         armed_q;
   logic [N-1:0] cnt_q, cnt_d;
   logic [N-1:0] idx_q, idx_d;
   logic [W-1:0] best_q, best_d;
   logic [W-1:0] second_q, second_d;
   logic         bid_ready;
   logic         accept;

   // armed_q keeps bid_ready low until the first clock edge after reset is released
   assign bid_ready = armed_q && (state_q == StCollect);
   assign accept    = bid_ready && bus.bid_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StCollect;
         armed_q  <= 1'b0;
         cnt_q    <= '0;
         idx_q    <= '0;
         best_q   <= '0;
         second_q <= '0;
      end else begin
         state_q  <= state_d;
         armed_q  <= 1'b1;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         best_q   <= best_d;
         second_q <= second_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      best_d   = best_q;
      second_d = second_q;
      case (state_q)
         StCollect: begin
            if (accept) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == '0) begin
                  best_d   = bus.bid_in;
                  second_d = '0;
                  idx_d    = '0;
               end else if (bus.bid_in > best_q) begin
                  // strict compare keeps the earliest bidder on ties
                  second_d = best_q;
                  best_d   = bus.bid_in;
                  idx_d    = cnt_q;
               end else if (bus.bid_in > second_q) begin
                  second_d = bus.bid_in;
               end
               if (cnt_q == CntLast) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            if (bus.result_ready) begin
               state_d = StCollect;
            end
         end
         default: state_d = StCollect;
      endcase
   end

   assign bus.bid_ready    = bid_ready;
   assign bus.result_valid = (state_q == StDone);
   assign bus.winner       = idx_q;
   assign bus.winning_bid  = best_q;
   assign bus.price        = (SECOND_PRICE != 0) ? second_q : best_q;

endmodule

// File: tb/tb_auction_seq.sv
// Bench for auction_seq: directed rounds on N=2/W=4 (both pricing modes) plus randomized
// rounds on N=1 and N=3 with W=8, all checked against a round-level reference model.
module tb_auction_seq;

   logic       clk;
   logic       rst;
   logic [7:0] dir_bid;
   logic       dir_valid;
   logic       dir_rready;

   logic [7:0] t_winner [4];
   logic [7:0] t_best   [4];
   logic [7:0] t_price  [4];
   logic       t_bready [4];
   logic       t_rvalid [4];
   int         t_rounds [4];

   int tests;
   int fails;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Instances 0/1 share directed stimulus (second-/first-price); 2/3 are randomized.
   for (genvar g = 0; g < 4; g++) begin : g_inst
      localparam int unsigned NN = (g == 2) ? 1 : (g == 3) ? 3 : 2;
      localparam int unsigned WW = (g < 2) ? 4 : 8;
      localparam int unsigned SP = (g == 1 || g == 3) ? 0 : 1;
      localparam int unsigned NB = 1 << NN;

      auction_seq_if #(.N(NN), .W(WW)) bus ();

      auction_seq #(.N(NN), .W(WW), .SECOND_PRICE(SP)) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );

      if (g < 2) begin : g_dir
         assign bus.bid_in       = dir_bid[WW-1:0];
         assign bus.bid_valid    = dir_valid;
         assign bus.result_ready = dir_rready;
      end else begin : g_rnd
         logic [WW-1:0] rb;
         logic          rv;
         logic          rr;
         assign bus.bid_in       = rb;
         assign bus.bid_valid    = rv;
         assign bus.result_ready = rr;
         initial begin
            rb = '0;
            rv = 1'b0;
            rr = 1'b0;
            forever begin
               @(negedge clk);
               rv = ($urandom_range(0, 3) != 0);
               // half the bids drawn from a tiny range so ties are common
               rb = ($urandom_range(0, 1) != 0) ? WW'($urandom_range(0, 3)) : WW'($urandom);
               rr = ($urandom_range(0, 2) != 0);
            end
         end
      end

      // Reference model: collect a round's bids, then resolve it as a max scan.
      int bids[$];
      bit exp_done;
      bit armed;
      int exp_win;
      int exp_best;
      int exp_price;
      int rounds;
      int sec;

      initial begin
         bids.delete();
         exp_done  = 1'b0;
         armed     = 1'b0;
         exp_win   = 0;
         exp_best  = 0;
         exp_price = 0;
         rounds    = 0;
         forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
               bids.delete();
               exp_done  = 1'b0;
               armed     = 1'b0;
               exp_win   = 0;
               exp_best  = 0;
               exp_price = 0;
            end else begin
               if (exp_done) begin
                  if (bus.result_ready) exp_done = 1'b0;
               end else if (armed && bus.bid_valid) begin
                  bids.push_back(int'(bus.bid_in));
                  if (bids.size() == NB) begin
                     exp_win  = 0;
                     exp_best = bids[0];
                     for (int i = 1; i < NB; i++) begin
                        if (bids[i] > exp_best) begin
                           exp_best = bids[i];
                           exp_win  = i;
                        end
                     end
                     sec = 0;
                     for (int i = 0; i < NB; i++) begin
                        if (i != exp_win && bids[i] > sec) sec = bids[i];
                     end
                     exp_price = (SP != 0) ? sec : exp_best;
                     exp_done  = 1'b1;
                     rounds++;
                     bids.delete();
                  end
               end
               armed = 1'b1;
            end
         end
      end

      always @(negedge clk) begin
         if (rst) begin
            check($sformatf("i%0d.rst_ready", g), int'(bus.bid_ready), 0);
            check($sformatf("i%0d.rst_valid", g), int'(bus.result_valid), 0);
            check($sformatf("i%0d.rst_winner", g), int'(bus.winner), 0);
            check($sformatf("i%0d.rst_best", g), int'(bus.winning_bid), 0);
            check($sformatf("i%0d.rst_price", g), int'(bus.price), 0);
         end else begin
            check($sformatf("i%0d.bid_ready", g), int'(bus.bid_ready),
                  (armed && !exp_done) ? 1 : 0);
            check($sformatf("i%0d.result_valid", g), int'(bus.result_valid), exp_done ? 1 : 0);
            if (exp_done) begin
               check($sformatf("i%0d.winner", g), int'(bus.winner), exp_win);
               check($sformatf("i%0d.winning_bid", g), int'(bus.winning_bid), exp_best);
               check($sformatf("i%0d.price", g), int'(bus.price), exp_price);
            end
         end
      end

      assign t_winner[g] = 8'(bus.winner);
      assign t_best[g]   = 8'(bus.winning_bid);
      assign t_price[g]  = 8'(bus.price);
      assign t_bready[g] = bus.bid_ready;
      assign t_rvalid[g] = bus.result_valid;
      assign t_rounds[g] = rounds;
   end

   // Four bids on the directed instances, with `gap` idle cycles between them.
   task automatic run_round(input int b0, input int b1, input int b2, input int b3,
                            input int gap, input string tag);
      int v[4];
      v[0] = b0;
      v[1] = b1;
      v[2] = b2;
      v[3] = b3;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         dir_bid   = 8'(v[i]);
         dir_valid = 1'b1;
         if (i == 3) check({tag, ".pre_valid"}, int'(t_rvalid[0]), 0);
         if (i < 3) begin
            for (int k = 0; k < gap; k++) begin
               @(negedge clk);
               dir_valid = 1'b0;
               dir_bid   = 8'($urandom);
            end
         end
      end
      @(negedge clk);
      dir_valid = 1'b0;
   endtask

   task automatic expect_res(input string tag, input int w, input int b, input int p_sp,
                             input int p_fp);
      check({tag, ".valid"}, int'(t_rvalid[0]), 1);
      check({tag, ".winner"}, int'(t_winner[0]), w);
      check({tag, ".best"}, int'(t_best[0]), b);
      check({tag, ".price2"}, int'(t_price[0]), p_sp);
      check({tag, ".price1"}, int'(t_price[1]), p_fp);
   endtask

   task automatic take_result(input string tag);
      dir_rready = 1'b1;
      @(negedge clk);
      dir_rready = 1'b0;
      check({tag, ".ready_after"}, int'(t_bready[0]), 1);
      check({tag, ".valid_after"}, int'(t_rvalid[0]), 0);
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      rst        = 1'b1;
      dir_bid    = '0;
      dir_valid  = 1'b0;
      dir_rready = 1'b0;
      #1;
      check("por.ready", int'(t_bready[0]), 0);
      check("por.valid", int'(t_rvalid[0]), 0);
      check("por.best", int'(t_best[0]), 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;

      run_round(3, 9, 5, 7, 0, "r1");
      expect_res("r1", 1, 9, 7, 9);
      take_result("r1");

      run_round(6, 6, 2, 6, 0, "r2");
      expect_res("r2", 0, 6, 6, 6);
      take_result("r2");

      run_round(0, 0, 0, 15, 2, "r3");
      expect_res("r3", 3, 15, 0, 15);

      // result held back while bids keep arriving: nothing may be consumed
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         dir_valid = 1'b1;
         dir_bid   = 8'd13;
         check("hold.ready", int'(t_bready[0]), 0);
         check("hold.winner", int'(t_winner[0]), 3);
         check("hold.best", int'(t_best[0]), 15);
         check("hold.price", int'(t_price[0]), 0);
      end
      dir_valid = 1'b0;
      take_result("r3");

      run_round(1, 1, 1, 1, 0, "r4");
      expect_res("r4", 0, 1, 1, 1);
      take_result("r4");

      @(negedge clk);
      dir_bid   = 8'd5;
      dir_valid = 1'b1;
      @(negedge clk);
      dir_bid   = 8'd11;
      @(negedge clk);
      dir_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("mid_rst.best", int'(t_best[0]), 0);
      check("mid_rst.winner", int'(t_winner[0]), 0);
      check("mid_rst.price", int'(t_price[1]), 0);
      check("mid_rst.ready", int'(t_bready[0]), 0);
      check("mid_rst.valid", int'(t_rvalid[0]), 0);
      @(negedge clk);
      #2 rst = 1'b0;

      run_round(1, 2, 3, 4, 0, "r5");
      expect_res("r5", 3, 4, 3, 4);
      take_result("r5");

      for (int c = 0; c < 60000; c++) begin
         if (t_rounds[2] >= 1000 && t_rounds[3] >= 1000) break;
         @(negedge clk);
      end
      check("rand_rounds_n1", (t_rounds[2] >= 1000) ? 1 : 0, 1);
      check("rand_rounds_n3", (t_rounds[3] >= 1000) ? 1 : 0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
